// File: rtl/life_pkg.sv
// life_pkg: shared FSM state type, popcount and count-width helpers for the life engine
package life_pkg;

    typedef enum logic [1:0] {IDLE, STEP, DONE} life_state_e;

    localparam int MAX_W    = 256;
    localparam int MAX_PC_W = $clog2(MAX_W + 1);

    function automatic logic [MAX_PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [MAX_PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_W; i++) s += MAX_PC_W'(v[i]);
        return s;
    endfunction

    function automatic int cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// life_row_rule: next-generation bits of one row from its above/current/below neighbour rows
module life_row_rule #(
    parameter int GRID_W = 64
) (
    input  logic [GRID_W-1:0] above_i,
    input  logic [GRID_W-1:0] cur_i,
    input  logic [GRID_W-1:0] below_i,
    input  logic              wrap_i,
    output logic [GRID_W-1:0] next_o
);

    logic [GRID_W-1:0] al, ar, cl, cr, bl, br;

    // x_l[c] is the cell at column c-1, x_r[c] at column c+1; edge columns wrap or read dead
    always_comb begin
        al = {above_i[GRID_W-2:0], wrap_i & above_i[GRID_W-1]};
        ar = {wrap_i & above_i[0], above_i[GRID_W-1:1]};
        cl = {cur_i[GRID_W-2:0], wrap_i & cur_i[GRID_W-1]};
        cr = {wrap_i & cur_i[0], cur_i[GRID_W-1:1]};
        bl = {below_i[GRID_W-2:0], wrap_i & below_i[GRID_W-1]};
        br = {wrap_i & below_i[0], below_i[GRID_W-1:1]};
    end

    for (genvar c = 0; c < GRID_W; c++) begin : g_col
        logic [3:0] n;
        assign n = 4'(al[c]) + 4'(above_i[c]) + 4'(ar[c]) + 4'(cl[c]) + 4'(cr[c])
                 + 4'(bl[c]) + 4'(below_i[c]) + 4'(br[c]);
        assign next_o[c] = (n == 4'd3) | (cur_i[c] & (n == 4'd2));
    end

endmodule

// File: rtl/life_engine.sv
// life_engine: register-held Game-of-Life grid advanced one row per clock
module life_engine
    import life_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 64,
    parameter int GEN_W  = 32,
    localparam int RW    = $clog2(GRID_H),
    localparam int CW    = cnt_w(GRID_W, GRID_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrap_en,
    input  logic              step,
    input  logic              run,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [RW-1:0]     load_row,
    input  logic [GRID_W-1:0] load_data,
    output logic              load_ready,
    input  logic [RW-1:0]     rd_row,
    output logic [GRID_W-1:0] rd_data,
    output logic              busy,
    output logic              gen_done,
    output logic [GEN_W-1:0]  generation,
    output logic [CW-1:0]     alive_count,
    output logic              stable
);

    typedef logic [GRID_W-1:0] row_t;

    localparam logic [RW-1:0] LAST = RW'(GRID_H - 1);

    life_state_e state_q;
    row_t        grid_q [GRID_H];
    row_t        prev_q, first_q, rd_data_q;
    logic [RW-1:0] r_q;
    logic        wrap_q, acc_chg_q, busy_q, done_q, ready_q, stable_q;
    logic [CW-1:0] acc_cnt_q, alive_q;
    logic [GEN_W-1:0] gen_q;

    row_t        cur_d, above_d, below_d, next_d;
    logic [RW-1:0] r_nxt_d;
    logic [CW-1:0] cnt_d;
    logic        chg_d;

    // Sliding window: prev_q holds the old copy of the row just overwritten, first_q the old row 0
    always_comb begin
        r_nxt_d = (r_q == LAST) ? '0 : r_q + RW'(1);
        cur_d   = grid_q[r_q];
        above_d = (r_q == '0) ? (wrap_q ? grid_q[GRID_H-1] : '0) : prev_q;
        below_d = (r_q == LAST) ? (wrap_q ? first_q : '0) : grid_q[r_nxt_d];
        cnt_d   = ((r_q == '0) ? '0 : acc_cnt_q) + CW'(popcount(MAX_W'(next_d)));
        chg_d   = ((r_q != '0) & acc_chg_q) | (next_d != cur_d);
    end

    life_row_rule #(.GRID_W(GRID_W)) u_rule (
        .above_i(above_d),
        .cur_i  (cur_d),
        .below_i(below_d),
        .wrap_i (wrap_q),
        .next_o (next_d)
    );

    // Control FSM with row counter, per-generation accumulators and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            r_q       <= '0;
            prev_q    <= '0;
            first_q   <= '0;
            wrap_q    <= 1'b0;
            acc_cnt_q <= '0;
            acc_chg_q <= 1'b0;
            gen_q     <= '0;
            alive_q   <= '0;
            stable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else if (state_q == IDLE) begin
            if (clear) begin
                gen_q    <= '0;
                alive_q  <= '0;
                stable_q <= 1'b0;
            end else if (step | run) begin
                state_q <= STEP;
                r_q     <= '0;
                wrap_q  <= wrap_en;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
            end
        end else if (state_q == STEP) begin
            r_q       <= r_nxt_d;
            prev_q    <= cur_d;
            acc_cnt_q <= cnt_d;
            acc_chg_q <= chg_d;
            if (r_q == '0) first_q <= cur_d;
            if (r_q == LAST) begin
                state_q  <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                gen_q    <= gen_q + GEN_W'(1);
                alive_q  <= cnt_d;
                stable_q <= !chg_d;
            end
        end else begin
            done_q <= 1'b0;
            if (run) begin
                state_q <= STEP;
                r_q     <= '0;
                wrap_q  <= wrap_en;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                ready_q <= 1'b1;
            end
        end
    end

    // Grid storage: clear beats load, rows rewritten in place while stepping; readback port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < GRID_H; i++) grid_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= grid_q[rd_row];
            if (state_q == IDLE && clear) begin
                for (int i = 0; i < GRID_H; i++) grid_q[i] <= '0;
            end else if (state_q == IDLE && load_valid) begin
                grid_q[load_row] <= load_data;
            end else if (state_q == STEP) begin
                grid_q[r_q] <= next_d;
            end
        end
    end

    assign load_ready  = ready_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign gen_done    = done_q;
    assign generation  = gen_q;
    assign alive_count = alive_q;
    assign stable      = stable_q;

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of an 8x8 engine and a 16x5 torus engine
module tb_life_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrap_en = 1'b0, step = 1'b0, run = 1'b0, clear = 1'b0, load_valid = 1'b0;
    logic [2:0]  load_row = '0, rd_row = '0;
    logic [7:0]  load_data = '0, rd_data;
    logic        load_ready, busy, gen_done, stable;
    logic [31:0] generation;
    logic [6:0]  alive_count;

    logic        b_step = 1'b0, b_load_valid = 1'b0;
    logic [2:0]  b_load_row = '0, b_rd_row = '0;
    logic [15:0] b_load_data = '0, b_rd_data;
    logic        b_load_ready, b_busy, b_gen_done, b_stable;
    logic [31:0] b_generation;
    logic [6:0]  b_alive_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    life_engine #(.GRID_W(8), .GRID_H(8), .GEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .wrap_en(wrap_en), .step(step), .run(run), .clear(clear),
        .load_valid(load_valid), .load_row(load_row), .load_data(load_data),
        .load_ready(load_ready), .rd_row(rd_row), .rd_data(rd_data), .busy(busy),
        .gen_done(gen_done), .generation(generation), .alive_count(alive_count), .stable(stable)
    );

    life_engine #(.GRID_W(16), .GRID_H(5), .GEN_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .wrap_en(1'b1), .step(b_step), .run(1'b0), .clear(1'b0),
        .load_valid(b_load_valid), .load_row(b_load_row), .load_data(b_load_data),
        .load_ready(b_load_ready), .rd_row(b_rd_row), .rd_data(b_rd_data), .busy(b_busy),
        .gen_done(b_gen_done), .generation(b_generation), .alive_count(b_alive_count),
        .stable(b_stable)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int row, input logic [7:0] d);
        load_valid = 1'b1;
        load_row   = 3'(row);
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic chkrow(input string tag, input int row, input logic [7:0] exp);
        rd_row = 3'(row);
        tick();
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic chkrow_b(input string tag, input int row, input logic [15:0] exp);
        b_rd_row = 3'(row);
        tick();
        chk(tag, 64'(b_rd_data), 64'(exp));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // one generation via step; reports cycles from the step cycle until gen_done is seen
    task automatic do_step(output int n);
        step = 1'b1;
        tick();
        step = 1'b0;
        n = 1;
        while (!gen_done && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("step_timeout", 64'(gen_done), 64'd1);
        tick();
    endtask

    // free-run until generation reaches target, dropping run inside the last generation
    task automatic run_to(input int target, output int pulses);
        int n;
        n = 0;
        pulses = 0;
        run = 1'b1;
        while (generation != 32'(target) && n < 2000) begin
            tick();
            n++;
            if (gen_done) pulses++;
            if (busy && generation == 32'(target - 1)) run = 1'b0;
        end
        run = 1'b0;
        if (n >= 2000) chk("run_timeout", 64'(generation), 64'(target));
        tick();
    endtask

    initial begin
        int lat, pulses;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(gen_done), 64'd0);
        chk("rst_gen", 64'(generation), 64'd0);
        chk("rst_alive", 64'(alive_count), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        chk("rst_ready", 64'(load_ready), 64'd1);

        // blinker
        load(3, 8'h1C);
        do_step(lat);
        chk("blk_latency", 64'(lat), 64'd9);
        chk("blk_gen", 64'(generation), 64'd1);
        chk("blk_alive", 64'(alive_count), 64'd3);
        chk("blk_stable", 64'(stable), 64'd0);
        chkrow("blk_r2", 2, 8'h08);
        chkrow("blk_r3", 3, 8'h08);
        chkrow("blk_r4", 4, 8'h08);
        chk("blk_ready", 64'(load_ready), 64'd1);
        do_step(lat);
        chkrow("blk2_r2", 2, 8'h00);
        chkrow("blk2_r3", 3, 8'h1C);
        chk("blk2_gen", 64'(generation), 64'd2);

        // clear wins over step in the same cycle
        load(0, 8'hFF);
        clear = 1'b1;
        step = 1'b1;
        tick();
        clear = 1'b0;
        step = 1'b0;
        chk("clr_busy0", 64'(busy), 64'd0);
        tick();
        chk("clr_busy1", 64'(busy), 64'd0);
        chk("clr_gen", 64'(generation), 64'd0);
        chk("clr_alive", 64'(alive_count), 64'd0);
        chkrow("clr_r0", 0, 8'h00);
        chkrow("clr_r3", 3, 8'h00);

        // block still life
        load(3, 8'h18);
        load(4, 8'h18);
        do_step(lat);
        chk("sq_stable", 64'(stable), 64'd1);
        chk("sq_alive", 64'(alive_count), 64'd4);
        chkrow("sq_r3", 3, 8'h18);
        chkrow("sq_r4", 4, 8'h18);

        // torus glider: 4 single steps shift it by one row and one column
        do_clear();
        load(0, 8'h02);
        load(1, 8'h04);
        load(2, 8'h07);
        wrap_en = 1'b1;
        for (int i = 0; i < 4; i++) do_step(lat);
        chk("gl4_gen", 64'(generation), 64'd4);
        chk("gl4_alive", 64'(alive_count), 64'd5);
        chkrow("gl4_r0", 0, 8'h00);
        chkrow("gl4_r1", 1, 8'h04);
        chkrow("gl4_r2", 2, 8'h08);
        chkrow("gl4_r3", 3, 8'h0E);
        run_to(32, pulses);
        chk("gl_pulses", 64'(pulses), 64'd28);
        chk("gl_gen", 64'(generation), 64'd32);
        chk("gl_stable", 64'(stable), 64'd0);
        chk("gl_busy", 64'(busy), 64'd0);
        chkrow("gl_r0", 0, 8'h02);
        chkrow("gl_r1", 1, 8'h04);
        chkrow("gl_r2", 2, 8'h07);
        chkrow("gl_r3", 3, 8'h00);

        // dead edges: glider settles as a block in the bottom-right corner
        do_clear();
        load(0, 8'h02);
        load(1, 8'h04);
        load(2, 8'h07);
        wrap_en = 1'b0;
        run_to(40, pulses);
        chk("de_pulses", 64'(pulses), 64'd40);
        chk("de_stable", 64'(stable), 64'd1);
        chk("de_alive", 64'(alive_count), 64'd4);
        chkrow("de_r5", 5, 8'h00);
        chkrow("de_r6", 6, 8'hC0);
        chkrow("de_r7", 7, 8'hC0);

        // load and step while busy are dropped
        step = 1'b1;
        tick();
        load_valid = 1'b1;
        load_row   = 3'd0;
        load_data  = 8'hFF;
        tick();
        tick();
        load_valid = 1'b0;
        step = 1'b0;
        lat = 0;
        while (!gen_done && lat < 100) begin
            tick();
            lat++;
        end
        tick();
        tick();
        chk("bz_busy", 64'(busy), 64'd0);
        chk("bz_gen", 64'(generation), 64'd41);
        chkrow("bz_r0", 0, 8'h00);

        // reset while row 4 is being computed
        rd_row = 3'd7;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(gen_done), 64'd0);
        chk("mr_gen", 64'(generation), 64'd0);
        chk("mr_alive", 64'(alive_count), 64'd0);
        chk("mr_stable", 64'(stable), 64'd0);
        chk("mr_rd", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        chkrow("mr_r6", 6, 8'h00);
        chkrow("mr_r7", 7, 8'h00);
        chk("mr_ready", 64'(load_ready), 64'd1);

        // 16x5 torus: blinker straddling columns 15/0
        b_load_valid = 1'b1;
        b_load_row   = 3'd2;
        b_load_data  = 16'h8003;
        tick();
        b_load_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            b_step = 1'b1;
            tick();
            b_step = 1'b0;
            lat = 1;
            while (!b_gen_done && lat < 100) begin
                tick();
                lat++;
            end
            chk("nsq_latency", 64'(lat), 64'd6);
            chk("nsq_alive", 64'(b_alive_count), 64'd3);
            tick();
            chkrow_b("nsq_r1", 1, g == 0 ? 16'h0001 : 16'h0000);
            chkrow_b("nsq_r2", 2, g == 0 ? 16'h0001 : 16'h8003);
            chkrow_b("nsq_r3", 3, g == 0 ? 16'h0001 : 16'h0000);
        end
        chk("nsq_gen", 64'(b_generation), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
